// File: rtl/mips_ext_pkg.sv
// Shared types for the MIPS load-extension path.
//   ext_size_t   : access width encoding carried on the size port
//   ext_state_t  : occupancy of the output/skid register pair
//   ext_result_t : extended result record at the default 32-bit datapath width
package mips_ext_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } ext_size_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } ext_state_t;

  localparam int unsigned EXT_DEF_W = 32;

  typedef struct packed {
    logic [EXT_DEF_W-1:0] data;
    logic                 misalign;
  } ext_result_t;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry registered pipeline stage with a skid register.
// The output register (OR) drives the consumer directly; the skid register
// (SR) catches the one request that can arrive while OR is stalled, so the
// registered in_ready never has to react combinationally to out_ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready is registered)
//   in_data             : payload captured on an input transfer
//   out_valid/out_ready : downstream handshake
//   out_data            : payload held in OR
module ext_skid_buf
  import mips_ext_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  ext_state_t   state_r;
  logic [W-1:0] oreg_r;
  logic [W-1:0] sreg_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         accept_s;
  logic         drain_s;

  assign accept_s  = in_valid && in_ready_r;
  assign drain_s   = out_valid_r && out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = oreg_r;

  // Occupancy state machine; moves payloads between input, SR and OR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      oreg_r      <= '0;
      sreg_r      <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          // in_ready rises on the first clock after reset release
          in_ready_r <= 1'b1;
          if (accept_s) begin
            oreg_r      <= in_data;
            out_valid_r <= 1'b1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (accept_s && !drain_s) begin
            // OR is stalled: park the new request in SR and stop accepting
            sreg_r     <= in_data;
            in_ready_r <= 1'b0;
            state_r    <= TWO;
          end else if (accept_s) begin
            oreg_r <= in_data;
          end else if (drain_s) begin
            out_valid_r <= 1'b0;
            state_r     <= EMPTY;
          end
        end
        TWO: begin
          if (drain_s) begin
            oreg_r     <= sreg_r;
            sreg_r     <= '0;
            in_ready_r <= 1'b1;
            state_r    <= ONE;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/load_extend_pipe.sv
// Load-data extension unit for the memory/writeback path.
// Selects the byte/half/word lane of a raw memory word, sign- or zero-extends
// it, flags illegal alignments and reserved sizes, and registers the result
// through a two-entry skid buffer.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake
//   data_in, byte_off   : raw aligned word and byte address bits
//   size, is_signed     : access width (ext_size_t) and extension mode
//   out_valid/out_ready : result handshake
//   data_out, misalign  : extended result and error flag (0 data on error)
//   err_count           : saturating count of accepted erroneous requests
module load_extend_pipe
  import mips_ext_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OFF_W     = $clog2(DATA_W / 8),
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [OFF_W-1:0]     byte_off,
  input  logic [1:0]           size,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 misalign,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned PAY_W  = DATA_W + 1;

  logic [DATA_W-1:0]    shifted_s;
  logic [DATA_W-1:0]    ext_data_s;
  logic                 ext_err_s;
  logic                 half_fit_s;
  logic [PAY_W-1:0]     in_pay_s;
  logic [PAY_W-1:0]     out_pay_s;
  logic [ERR_CNT_W-1:0] err_count_r;

  // Bring the addressed lane down to bit 0 so every width reads from the bottom.
  assign shifted_s  = data_in >> {byte_off, 3'b000};
  assign half_fit_s = ((32'(byte_off) + 32'd2) <= NBYTES);

  // Lane select, extension and error detection.
  always_comb begin
    ext_data_s = '0;
    ext_err_s  = 1'b0;
    case (ext_size_t'(size))
      SZ_BYTE: begin
        ext_data_s = {{(DATA_W-8){is_signed & shifted_s[7]}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        if (!byte_off[0] && half_fit_s) begin
          ext_data_s = {{(DATA_W-16){is_signed & shifted_s[15]}}, shifted_s[15:0]};
        end else begin
          ext_err_s = 1'b1;
        end
      end
      SZ_WORD: begin
        if (byte_off == '0) begin
          ext_data_s = data_in;
        end else begin
          ext_err_s = 1'b1;
        end
      end
      default: begin
        ext_err_s = 1'b1;
      end
    endcase
  end

  assign in_pay_s = {ext_err_s, ext_data_s};

  ext_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay_s)
  );

  assign data_out  = out_pay_s[DATA_W-1:0];
  assign misalign  = out_pay_s[DATA_W];
  assign err_count = err_count_r;

  // Saturating count of accepted requests that evaluated to an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= '0;
    end else if (in_valid && in_ready && ext_err_s && (err_count_r != '1)) begin
      err_count_r <= err_count_r + ERR_CNT_W'(1);
    end else begin
      err_count_r <= err_count_r;
    end
  end

endmodule

// File: tb/tb_load_extend_pipe.sv
// Directed, table-driven bench for load_extend_pipe (32-bit datapath), plus
// hand-written sequences for backpressure, back-to-back flow, counter
// saturation (second instance with a 2-bit counter) and reset during a stall.
module tb_load_extend_pipe;

  typedef struct {
    logic [31:0] din;
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] exp_d;
    logic        exp_m;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [1:0]  byte_off;
  logic [1:0]  size;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        misalign;
  logic [7:0]  err_count;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] data_out2;
  logic        misalign2;
  logic [1:0]  err_count2;

  int          n_vec;
  int          n_bad;
  logic [7:0]  exp_err;
  vec_t        tbl[15];

  load_extend_pipe #(.DATA_W(32), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .byte_off(byte_off), .size(size), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .misalign(misalign), .err_count(err_count)
  );

  load_extend_pipe #(.DATA_W(32), .ERR_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .data_in(data_in), .byte_off(byte_off), .size(size), .is_signed(is_signed),
    .out_valid(out_valid2), .out_ready(out_ready2), .data_out(data_out2),
    .misalign(misalign2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request into an empty pipe; result must be visible one clock later.
  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    data_in   = v.din;
    byte_off  = v.off;
    size      = v.sz;
    is_signed = v.sgn;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    if (v.exp_m && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, data_out, v.exp_d);
    check({tag, "_misalign"}, 32'(misalign), 32'(v.exp_m));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
  endtask

  // Stream n word requests (expected = data word) with out_ready low for the
  // first 'stall' cycles; checks order, loss, and handshake continuity.
  task automatic run_stream(input string tag, input int n, input int stall, input logic [31:0] base);
    logic [31:0] expq[$];
    int idx   = 0;
    int got   = 0;
    int cyc   = 0;
    int gaps  = 0;
    int drops = 0;
    while ((idx < n || expq.size() != 0) && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if ((idx - got) > 0 && !out_valid) gaps++;
      if (stall > 0 && cyc == stall - 1) begin
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        check({tag, "_accepted_while_stalled"}, 32'(idx), 32'd2);
        check({tag, "_held_data"}, data_out, base);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check({tag, "_unexpected_result"}, data_out, 32'hxxxx_xxxx);
        end else begin
          check($sformatf("%s_result%0d", tag, got), data_out, expq.pop_front());
          got++;
        end
      end
      if (idx < n) begin
        in_valid  = 1'b1;
        data_in   = base + 32'(idx);
        byte_off  = 2'd0;
        size      = 2'b10;
        is_signed = 1'b0;
        if (stall == 0 && !in_ready) drops++;
        if (in_ready) begin
          expq.push_back(base + 32'(idx));
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_completed"}, 32'(got), 32'(n));
    check({tag, "_no_output_gap"}, 32'(gaps), 32'd0);
    if (stall == 0) check({tag, "_in_ready_steady"}, 32'(drops), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    exp_err    = 8'd0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    data_in    = 32'd0;
    byte_off   = 2'd0;
    size       = 2'd0;
    is_signed  = 1'b0;

    //            din           off   sz     sgn   exp_d         exp_m
    tbl[0]  = '{32'h80FF_7F01, 2'd3, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{32'h80FF_7F01, 2'd3, 2'b00, 1'b0, 32'h0000_0080, 1'b0};
    tbl[2]  = '{32'h80FF_7F01, 2'd0, 2'b00, 1'b1, 32'h0000_0001, 1'b0};
    tbl[3]  = '{32'h80FF_7F01, 2'd2, 2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{32'h80FF_7F01, 2'd1, 2'b00, 1'b0, 32'h0000_007F, 1'b0};
    tbl[5]  = '{32'h8001_1234, 2'd2, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0};
    tbl[6]  = '{32'h8001_1234, 2'd1, 2'b01, 1'b1, 32'h0000_0000, 1'b1};
    tbl[7]  = '{32'h8001_1234, 2'd0, 2'b01, 1'b1, 32'h0000_1234, 1'b0};
    tbl[8]  = '{32'h8001_1234, 2'd2, 2'b01, 1'b0, 32'h0000_8001, 1'b0};
    tbl[9]  = '{32'h8001_1234, 2'd0, 2'b10, 1'b1, 32'h8001_1234, 1'b0};
    tbl[10] = '{32'h8001_1234, 2'd2, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
    tbl[11] = '{32'h8001_1234, 2'd0, 2'b11, 1'b0, 32'h0000_0000, 1'b1};
    tbl[12] = '{32'h0000_F000, 2'd0, 2'b01, 1'b1, 32'hFFFF_F000, 1'b0};
    tbl[13] = '{32'h0000_F000, 2'd3, 2'b01, 1'b1, 32'h0000_0000, 1'b1};
    tbl[14] = '{32'h1234_5678, 2'd1, 2'b00, 1'b1, 32'h0000_0056, 1'b0};

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table of single requests through an empty pipe
    for (int i = 0; i < 15; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: 4 requests, consumer stalled for 6 cycles
    run_stream("bp", 4, 6, 32'hA000_0000);

    // Accept and drain together in ONE for 10 cycles
    run_stream("b2b", 10, 0, 32'hB000_0000);

    // Saturation on the 2-bit counter instance: 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid2 = 1'b1;
      size      = 2'b11;
      data_in   = 32'h5555_AAAA;
      byte_off  = 2'd0;
      check($sformatf("sat_in_ready%0d", k), 32'(in_ready2), 32'd1);
      if (k > 0) check($sformatf("sat_count%0d", k - 1), 32'(err_count2), (k > 3) ? 32'd3 : 32'(k));
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    check("sat_count4", 32'(err_count2), 32'd3);
    check("sat_misalign", 32'(misalign2), 32'd1);
    check("sat_data_zero", data_out2, 32'd0);

    // Reset while both registers are full
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; data_in = 32'hC000_0001; byte_off = 2'd0; size = 2'b10; is_signed = 1'b0;
    @(negedge clk);
    data_in = 32'hC000_0002;
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_full_in_ready", 32'(in_ready), 32'd0);
    check("stall_full_out_valid", 32'(out_valid), 32'd1);
    check("stall_err_count_before", 32'(err_count), 32'(exp_err));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    exp_err = 8'd0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    check("after_rst_no_stale", 32'(out_valid), 32'd0);
    apply_vec(tbl[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
